button_debouncer: RTL and testbench

//  Per-key debounce for the board push-buttons, upstream of the button PIO.

---
 rtl/button_debouncer_if.sv | 11 +
 rtl/button_debouncer.sv | 110 +++++++++++
 tb/tb_button_debouncer.sv | 102 ++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw key pins in, debounced levels and edge strobes out.
interface button_debouncer_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_db;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    modport master (output key_raw, input key_db, press_pulse, release_pulse);
    modport slave (input key_raw, output key_db, press_pulse, release_pulse);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: per-key 2-FF sync plus stability-count FSM producing clean levels
// and one-cycle press/release strobes.
module button_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    button_debouncer_if.slave   keys
);
    typedef enum logic [1:0] {REL, CHK_PRS, PRS, CHK_REL} state_t;

    localparam logic                 AL       = (ACTIVE_LOW != 0);
    localparam logic [N_KEYS-1:0]    REL_LVL  = {N_KEYS{AL}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0]    s1_q, s1_d, s2_q, s2_d;
    logic [N_KEYS-1:0]    key_db_q, key_db_d;
    logic [N_KEYS-1:0]    press_q, press_d, release_q, release_d;
    logic [N_KEYS-1:0]    prs;
    logic [CNT_WIDTH-1:0] cnt_q [N_KEYS];
    logic [CNT_WIDTH-1:0] cnt_d [N_KEYS];
    state_t               state_q [N_KEYS];
    state_t               state_d [N_KEYS];

    // prs is 1 where the synchronised pin is at its pressed level
    assign prs = s2_q ^ REL_LVL;

    always_comb begin
        s1_d = keys.key_raw;
        s2_d = s1_q;
        key_db_d = key_db_q;
        press_d = '0;
        release_d = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k] = cnt_q[k];
            case (state_q[k])
                REL: begin
                    if (prs[k]) begin
                        state_d[k] = CHK_PRS;
                        cnt_d[k] = CNT_WIDTH'(1);
                    end
                end
                CHK_PRS: begin
                    if (!prs[k]) begin
                        state_d[k] = REL;
                        cnt_d[k] = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = PRS;
                        cnt_d[k] = '0;
                        key_db_d[k] = ~AL;
                        press_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                    end
                end
                PRS: begin
                    if (!prs[k]) begin
                        state_d[k] = CHK_REL;
                        cnt_d[k] = CNT_WIDTH'(1);
                    end
                end
                default: begin
                    if (prs[k]) begin
                        state_d[k] = PRS;
                        cnt_d[k] = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = REL;
                        cnt_d[k] = '0;
                        key_db_d[k] = AL;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= REL_LVL;
            s2_q <= REL_LVL;
            key_db_q <= REL_LVL;
            press_q <= '0;
            release_q <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                state_q[k] <= REL;
                cnt_q[k] <= '0;
            end
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            key_db_q <= key_db_d;
            press_q <= press_d;
            release_q <= release_d;
            for (int k = 0; k < N_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign keys.key_db = key_db_q;
    assign keys.press_pulse = press_q;
    assign keys.release_pulse = release_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed per-cycle vectors; expected outputs queued by the
// stimulus and checked by an independent monitor just after each rising edge.
module tb_button_debouncer;
    typedef struct {
        logic [3:0] db;
        logic [3:0] pr;
        logic [3:0] rl;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    exp_t exp_q[$];

    button_debouncer_if #(.N_KEYS(4)) bif ();

    button_debouncer #(
        .N_KEYS(4), .CNT_WIDTH(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .keys(bif)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rn, input logic [3:0] raw,
                        input logic [3:0] db, input logic [3:0] pr, input logic [3:0] rl);
        exp_t e;
        @(negedge clk);
        reset_n = rn;
        bif.key_raw = raw;
        step_id++;
        e.db = db;
        e.pr = pr;
        e.rl = rl;
        e.id = step_id;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bif.key_db !== e.db) begin
                    errors++;
                    $display("FAIL key_db step %0d: got %h expected %h", e.id, bif.key_db, e.db);
                end
                checks++;
                if (bif.press_pulse !== e.pr) begin
                    errors++;
                    $display("FAIL press_pulse step %0d: got %h expected %h", e.id, bif.press_pulse, e.pr);
                end
                checks++;
                if (bif.release_pulse !== e.rl) begin
                    errors++;
                    $display("FAIL release_pulse step %0d: got %h expected %h", e.id, bif.release_pulse, e.rl);
                end
            end
        end
    end

    initial begin
        bif.key_raw = 4'hF;
        // reset held, then idle released
        for (int i = 0; i < 3; i++) step(1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
        // bit0 press then release: change lands 10 edges after first sample
        for (int i = 1; i <= 12; i++) step(1'b1, 4'hE, (i >= 10) ? 4'hE : 4'hF, (i == 10) ? 4'h1 : 4'h0, 4'h0);
        for (int i = 1; i <= 12; i++) step(1'b1, 4'hF, (i >= 10) ? 4'hF : 4'hE, 4'h0, (i == 10) ? 4'h1 : 4'h0);
        // bit1 bounces in 3-cycle runs, then settles low
        for (int c = 0; c < 30; c++) step(1'b1, {2'b11, ((c / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b1}, 4'hF, 4'h0, 4'h0);
        for (int i = 1; i <= 12; i++) step(1'b1, 4'hD, (i >= 10) ? 4'hD : 4'hF, (i == 10) ? 4'h2 : 4'h0, 4'h0);
        for (int i = 1; i <= 12; i++) step(1'b1, 4'hF, (i >= 10) ? 4'hF : 4'hD, 4'h0, (i == 10) ? 4'h2 : 4'h0);
        // bit2 low for one cycle short of qualification
        for (int i = 0; i < 7; i++) step(1'b1, 4'hB, 4'hF, 4'h0, 4'h0);
        for (int i = 0; i < 15; i++) step(1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
        // bits 0 and 3 together
        for (int i = 1; i <= 12; i++) step(1'b1, 4'h6, (i >= 10) ? 4'h6 : 4'hF, (i == 10) ? 4'h9 : 4'h0, 4'h0);
        for (int i = 1; i <= 12; i++) step(1'b1, 4'hF, (i >= 10) ? 4'hF : 4'h6, 4'h0, (i == 10) ? 4'h9 : 4'h0);
        // reset mid-count discards 5 counted cycles
        for (int i = 0; i < 7; i++) step(1'b1, 4'hE, 4'hF, 4'h0, 4'h0);
        for (int i = 0; i < 2; i++) step(1'b0, 4'hE, 4'hF, 4'h0, 4'h0);
        for (int i = 1; i <= 12; i++) step(1'b1, 4'hE, (i >= 10) ? 4'hE : 4'hF, (i == 10) ? 4'h1 : 4'h0, 4'h0);
        for (int i = 1; i <= 12; i++) step(1'b1, 4'hF, (i >= 10) ? 4'hF : 4'hE, 4'h0, (i == 10) ? 4'h1 : 4'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
